// File: rtl/dbi_pkg.sv
// Shared DBI definitions: default lane geometry and bit-count helper used on
// both the encoder and decoder sides of the link.
package dbi_pkg;

  localparam int DBI_BW    = 4;
  localparam int DBI_LANES = 4;
  localparam int DBI_POP_W = 64;

  function automatic logic [6:0] popcount(input logic [DBI_POP_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < DBI_POP_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dbi_skid_fifo.sv
// Two-entry skid FIFO; readiness depends only on registered occupancy so the
// upstream never sees a combinational path from the downstream ready.
module dbi_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
    unique case (count_q)
      2'd0: if (push) head_d = in_data_i;
      2'd1: begin
        if (push && pop) head_d = in_data_i;
        else if (push)   tail_d = in_data_i;
      end
      2'd2: if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  // head is cleared on reset so the idle output reads zero; tail needs no reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

endmodule

// File: rtl/dbi_decode_stage.sv
// Receiver-side DBI decode: strips lane flags, buffers decoded words in a
// skid FIFO and keeps saturating toggle / inversion statistics.
module dbi_decode_stage
  import dbi_pkg::*;
#(
  parameter int bw    = DBI_BW,
  parameter int lanes = DBI_LANES,
  parameter int cnt_w = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dbi_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [lanes*(bw+1)-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [lanes*bw-1:0]      out_data,
  input  logic                     cnt_clr,
  output logic [cnt_w-1:0]         toggle_cnt,
  output logic [cnt_w-1:0]         inv_cnt
);

  localparam int EW    = lanes * (bw + 1);
  localparam int SUM_W = cnt_w + $clog2(EW + 1);

  logic [EW-1:0]       prev_bus_q, prev_bus_d;
  logic [cnt_w-1:0]    toggle_q, toggle_d;
  logic [cnt_w-1:0]    inv_q, inv_d;
  logic [lanes*bw-1:0] dec_word;
  logic [SUM_W-1:0]    tog_inc, inv_inc;
  logic                accept;

  function automatic logic [cnt_w-1:0] sat_add(input logic [cnt_w-1:0] a,
                                               input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = {{(SUM_W-cnt_w){1'b0}}, a} + inc;
    if (s > {{(SUM_W-cnt_w){1'b0}}, {cnt_w{1'b1}}}) return '1;
    return s[cnt_w-1:0];
  endfunction

  always_comb begin
    dec_word = '0;
    inv_inc  = '0;
    for (int i = 0; i < lanes; i++) begin
      if (dbi_en && in_data[i*(bw+1)+bw]) begin
        dec_word[i*bw +: bw] = ~in_data[i*(bw+1) +: bw];
        inv_inc              = inv_inc + 1'b1;
      end else begin
        dec_word[i*bw +: bw] = in_data[i*(bw+1) +: bw];
      end
    end
  end

  assign tog_inc = SUM_W'(popcount(DBI_POP_W'(prev_bus_q ^ in_data)));
  assign accept  = in_valid && in_ready;

  // clear has priority over a same-cycle increment; prev_bus follows accepts only
  always_comb begin
    prev_bus_d = accept ? in_data : prev_bus_q;
    toggle_d   = toggle_q;
    inv_d      = inv_q;
    if (cnt_clr) begin
      toggle_d = '0;
      inv_d    = '0;
    end else if (accept) begin
      toggle_d = sat_add(toggle_q, tog_inc);
      inv_d    = sat_add(inv_q, inv_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_bus_q <= '0;
      toggle_q   <= '0;
      inv_q      <= '0;
    end else begin
      prev_bus_q <= prev_bus_d;
      toggle_q   <= toggle_d;
      inv_q      <= inv_d;
    end
  end

  assign toggle_cnt = toggle_q;
  assign inv_cnt    = inv_q;

  dbi_skid_fifo #(.W(lanes*bw)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (dec_word),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data)
  );

endmodule
